// File: rtl/puf_pkg.sv
// Shared types and helpers for the PUF scan-chain model.
// FSM states, response-function encodings and a per-bit response helper.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READY,
    EVAL,
    UNLOAD
  } puf_state_e;

  localparam int PUF_MODE_ORAND = 0;
  localparam int PUF_MODE_XOR   = 1;

  // Returns {up, down} for one bit; b_rot is bit i of rotl1(B), i.e. B[i-1].
  function automatic logic [1:0] resp_bit(
    input int   mode,
    input logic a,
    input logic b,
    input logic b_rot
  );
    logic [1:0] r;
    if (mode == PUF_MODE_XOR)
      r = {a ^ b, ~(a ^ b_rot)};
    else
      r = {a | b, a & b};
    return r;
  endfunction

endpackage

// File: rtl/puf_shift_reg.sv
// Right-shift register with serial input and parallel load.
// Load takes priority over shift; the bit at index 0 leaves first.
module puf_shift_reg #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         si,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Whole-word load or single-bit right shift, never both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      q <= '0;
    else if (ld)
      q <= d;
    else if (en)
      q <= {si, q[W-1:1]};
  end

endmodule

// File: rtl/puf_scan_model_p.sv
// Cycle-accurate stand-in for the PUF scan-chain interface.
// Serial challenge load, timed evaluation, serial response unload.
module puf_scan_model_p
  import puf_pkg::*;
#(
  parameter int CHAL_W      = 128,
  parameter int EVAL_CYCLES = 4,
  parameter int MODE        = 0,
  parameter int CNT_W       = $clog2(CHAL_W + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ca_si,
  input  logic cb_si,
  input  logic ph_en,
  input  logic trig,
  input  logic out_en,
  output logic so_up,
  output logic so_not_up,
  output logic so_down,
  output logic so_not_down,
  output logic ca_out,
  output logic cb_out,
  output logic busy,
  output logic chal_full,
  output logic resp_valid,
  output logic err
);

  localparam int EW = $clog2(EVAL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CHAL_W);
  localparam logic [EW-1:0] E_LD = EW'(EVAL_CYCLES - 1);

  puf_state_e state;

  logic trig_q;
  logic trig_rise;
  logic shift_in;
  logic shift_out;
  logic load_resp;
  logic bad;
  logic unload_done;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] ucnt;
  logic [EW-1:0]    ecnt;

  logic [CHAL_W-1:0] a_q;
  logic [CHAL_W-1:0] b_q;
  logic [CHAL_W-1:0] up_q;
  logic [CHAL_W-1:0] dn_q;
  logic [CHAL_W-1:0] up_d;
  logic [CHAL_W-1:0] dn_d;
  logic              unused_resp;

  assign trig_rise = trig & ~trig_q;

  // Decide which request acts this cycle and which is refused.
  always_comb begin
    shift_in  = 1'b0;
    shift_out = 1'b0;
    load_resp = 1'b0;
    bad       = 1'b0;
    unique case (state)
      IDLE, LOAD: begin
        shift_in = ph_en;
        bad      = trig_rise | out_en;
      end
      READY: begin
        shift_in = ph_en & ~trig_rise;
        bad      = (ph_en & trig_rise) | out_en;
      end
      EVAL: begin
        load_resp = (ecnt == '0);
        bad       = trig_rise | ph_en | out_en;
      end
      UNLOAD: begin
        shift_out = out_en;
        bad       = trig_rise | ph_en;
      end
      default: ;
    endcase
  end

  // Saturating count of challenge bits shifted in.
  always_comb begin
    cnt_nxt = cnt;
    if (shift_in && cnt != FULL)
      cnt_nxt = cnt + 1'b1;
  end

  assign unload_done = shift_out && (ucnt == FULL - 1'b1);

  puf_shift_reg #(.W(CHAL_W)) u_chal_a (
    .clk(clk), .reset_n(reset_n), .en(shift_in), .si(ca_si),
    .ld(1'b0), .d('0), .q(a_q)
  );

  puf_shift_reg #(.W(CHAL_W)) u_chal_b (
    .clk(clk), .reset_n(reset_n), .en(shift_in), .si(cb_si),
    .ld(1'b0), .d('0), .q(b_q)
  );

  for (genvar i = 0; i < CHAL_W; i++) begin : g_resp
    localparam int J = (i == 0) ? CHAL_W - 1 : i - 1;
    assign {up_d[i], dn_d[i]} = resp_bit(MODE, a_q[i], b_q[i], b_q[J]);
  end

  puf_shift_reg #(.W(CHAL_W)) u_resp_up (
    .clk(clk), .reset_n(reset_n), .en(shift_out), .si(1'b0),
    .ld(load_resp), .d(up_d), .q(up_q)
  );

  puf_shift_reg #(.W(CHAL_W)) u_resp_dn (
    .clk(clk), .reset_n(reset_n), .en(shift_out), .si(1'b0),
    .ld(load_resp), .d(dn_d), .q(dn_q)
  );

  assign unused_resp = ^{up_q[CHAL_W-1:1], dn_q[CHAL_W-1:1]};

  assign so_up       = up_q[0];
  assign so_not_up   = ~up_q[0];
  assign so_down     = dn_q[0];
  assign so_not_down = ~dn_q[0];
  assign ca_out      = a_q[0];
  assign cb_out      = b_q[0];

  // Control FSM with registered status flags and error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      trig_q     <= 1'b0;
      cnt        <= '0;
      ucnt       <= '0;
      ecnt       <= '0;
      busy       <= 1'b0;
      chal_full  <= 1'b0;
      resp_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      trig_q    <= trig;
      err       <= bad;
      cnt       <= unload_done ? '0 : cnt_nxt;
      chal_full <= unload_done ? 1'b0 : (cnt_nxt == FULL);
      unique case (state)
        IDLE: begin
          if (ph_en)
            state <= LOAD;
        end
        LOAD: begin
          if (cnt_nxt == FULL)
            state <= READY;
        end
        READY: begin
          if (trig_rise) begin
            state <= EVAL;
            ecnt  <= E_LD;
            busy  <= 1'b1;
          end
        end
        EVAL: begin
          if (ecnt == '0) begin
            state      <= UNLOAD;
            resp_valid <= 1'b1;
            busy       <= 1'b0;
            ucnt       <= '0;
          end else begin
            ecnt <= ecnt - 1'b1;
          end
        end
        UNLOAD: begin
          if (shift_out)
            ucnt <= ucnt + 1'b1;
          if (unload_done) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_scan_model_p.sv
// Randomised bench for puf_scan_model_p, both response modes side by side.
// Expected values come from a bit-queue model of the challenge chains.
module tb_puf_scan_model_p;

  localparam int W  = 8;
  localparam int EC = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ca_si = 1'b0;
  logic cb_si = 1'b0;
  logic ph_en = 1'b0;
  logic trig = 1'b0;
  logic out_en = 1'b0;

  logic [1:0] so_up, so_not_up, so_down, so_not_down;
  logic [1:0] ca_out, cb_out, busy, chal_full, resp_valid, err;

  int n_chk = 0;
  int n_fail = 0;

  bit aq[$];
  bit bq[$];

  puf_scan_model_p #(.CHAL_W(W), .EVAL_CYCLES(EC), .MODE(0)) u_or (
    .clk(clk), .reset_n(reset_n), .ca_si(ca_si), .cb_si(cb_si),
    .ph_en(ph_en), .trig(trig), .out_en(out_en),
    .so_up(so_up[0]), .so_not_up(so_not_up[0]),
    .so_down(so_down[0]), .so_not_down(so_not_down[0]),
    .ca_out(ca_out[0]), .cb_out(cb_out[0]), .busy(busy[0]),
    .chal_full(chal_full[0]), .resp_valid(resp_valid[0]), .err(err[0])
  );

  puf_scan_model_p #(.CHAL_W(W), .EVAL_CYCLES(EC), .MODE(1)) u_xor (
    .clk(clk), .reset_n(reset_n), .ca_si(ca_si), .cb_si(cb_si),
    .ph_en(ph_en), .trig(trig), .out_en(out_en),
    .so_up(so_up[1]), .so_not_up(so_not_up[1]),
    .so_down(so_down[1]), .so_not_down(so_not_down[1]),
    .ca_out(ca_out[1]), .cb_out(cb_out[1]), .busy(busy[1]),
    .chal_full(chal_full[1]), .resp_valid(resp_valid[1]), .err(err[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    aq.delete();
    bq.delete();
    for (int i = 0; i < W; i++) begin
      aq.push_back(1'b0);
      bq.push_back(1'b0);
    end
  endtask

  function automatic logic [7:0] a_val();
    logic [7:0] v;
    for (int i = 0; i < W; i++) v[i] = aq[i];
    return v;
  endfunction

  function automatic logic [7:0] b_val();
    logic [7:0] v;
    for (int i = 0; i < W; i++) v[i] = bq[i];
    return v;
  endfunction

  function automatic logic [7:0] m_up(input int mode, input logic [7:0] a,
                                      input logic [7:0] b);
    return (mode == 0) ? (a | b) : (a ^ b);
  endfunction

  function automatic logic [7:0] m_dn(input int mode, input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] r;
    r = 8'(({8'h00, b} << 1) | ({8'h00, b} >> 7));
    return (mode == 0) ? (a & b) : ~(a ^ r);
  endfunction

  task automatic shift_in(input logic a, input logic b);
    ca_si = a;
    cb_si = b;
    ph_en = 1'b1;
    tick();
    ph_en = 1'b0;
    aq.push_back(a);
    bq.push_back(b);
    void'(aq.pop_front());
    void'(bq.pop_front());
  endtask

  task automatic chk_reset(input string tag);
    for (int d = 0; d < 2; d++)
      check(tag, 32'({so_up[d], so_not_up[d], so_down[d], so_not_down[d],
                      ca_out[d], cb_out[d], busy[d], chal_full[d],
                      resp_valid[d], err[d]}), 32'h140);
  endtask

  task automatic load8(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < W; i++) begin
      shift_in(a[i], b[i]);
      check("full_load", 32'(chal_full), (i == W - 1) ? 32'h3 : 32'h0);
    end
  endtask

  task automatic fire(input bit with_ph);
    trig = 1'b1;
    if (with_ph) begin
      ph_en = 1'b1;
      ca_si = 1'($urandom);
      cb_si = 1'($urandom);
    end
    tick();
    trig = 1'b0;
    ph_en = 1'b0;
    check("busy_eval", 32'(busy), 32'h3);
    check("err_fire", 32'(err), with_ph ? 32'h3 : 32'h0);
    for (int k = 0; k < EC - 1; k++) begin
      tick();
      check("rv_early", 32'(resp_valid), 32'h0);
    end
    tick();
    check("rv_latency", 32'(resp_valid), 32'h3);
    check("busy_done", 32'(busy), 32'h0);
  endtask

  task automatic unload();
    logic [7:0] u0, d0, u1, d1;
    u0 = m_up(0, a_val(), b_val());
    d0 = m_dn(0, a_val(), b_val());
    u1 = m_up(1, a_val(), b_val());
    d1 = m_dn(1, a_val(), b_val());
    for (int i = 0; i < W; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      check("so_orand", 32'({so_up[0], so_not_up[0], so_down[0], so_not_down[0]}),
            32'({u0[i], ~u0[i], d0[i], ~d0[i]}));
      check("so_xor", 32'({so_up[1], so_not_up[1], so_down[1], so_not_down[1]}),
            32'({u1[i], ~u1[i], d1[i], ~d1[i]}));
      out_en = 1'b1;
      tick();
      out_en = 1'b0;
    end
    check("rv_clear", 32'(resp_valid), 32'h0);
    check("full_clear", 32'(chal_full), 32'h0);
    check("err_unload", 32'(err), 32'h0);
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b);
    load8(a, b);
    fire(1'b0);
    unload();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] ra, rb;
    model_clear();
    reset_n = 1'b0;
    tick();
    tick();
    chk_reset("reset_state");
    reset_n = 1'b1;
    tick();

    run(8'hA5, 8'h3C);
    run(8'hF0, 8'h0F);

    ra = 8'($urandom);
    rb = 8'($urandom);
    for (int i = 0; i < 5; i++) shift_in(ra[i], rb[i]);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check("err_trig_load", 32'(err), 32'h3);
    check("busy_trig_load", 32'(busy), 32'h0);
    tick();
    check("err_pulse_end", 32'(err), 32'h0);
    for (int i = 5; i < W; i++) shift_in(ra[i], rb[i]);
    check("full_after_partial", 32'(chal_full), 32'h3);
    fire(1'b0);
    unload();

    ra = 8'($urandom);
    rb = 8'($urandom);
    load8(ra, rb);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #2;
    chk_reset("reset_async");
    tick();
    chk_reset("reset_hold");
    reset_n = 1'b1;
    model_clear();
    tick();
    run(ra, rb);

    load8(8'($urandom), 8'($urandom));
    fire(1'b1);
    unload();

    load8(8'($urandom), 8'($urandom));
    for (int k = 0; k < 2; k++) begin
      check("scan_ca", 32'(ca_out), aq[0] ? 32'h3 : 32'h0);
      check("scan_cb", 32'(cb_out), bq[0] ? 32'h3 : 32'h0);
      shift_in(1'($urandom), 1'($urandom));
      check("scan_full", 32'(chal_full), 32'h3);
    end
    fire(1'b0);
    unload();

    out_en = 1'b1;
    tick();
    out_en = 1'b0;
    check("err_out_idle", 32'(err), 32'h3);
    check("so_idle", 32'({so_up[0], so_not_up[0], so_down[0], so_not_down[0],
                          so_up[1], so_not_up[1], so_down[1], so_not_down[1]}),
          32'h55);
    tick();
    check("err_idle_end", 32'(err), 32'h0);

    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(0, 3)) tick();
      run(8'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
